// File: rtl/rb_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rb_pkt_pkg
// Purpose  : Shared types, constants and helpers for the rb packet reader.
//            - pkt_state_t : reader FSM state encoding
//            - CNT_W       : width of the delivered/dropped packet counters
//            - hdr_len()   : extracts the length field from a header word
// Revision : 1.0 - initial release
// ============================================================================
package rb_pkt_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        HDR     = 2'd0,
        PAYLOAD = 2'd1,
        DROP    = 2'd2
    } pkt_state_t;

    // Returns the low 'lw' bits of a header word; the caller narrows the
    // result to its own length-field width. Upper header bits are ignored.
    function automatic logic [63:0] hdr_len(input logic [63:0] data, input int lw);
        logic [63:0] mask;
        mask = (64'd1 << lw) - 64'd1;
        return data & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rb_if.sv
`default_nettype none
// ============================================================================
// Module   : rb_if
// Purpose  : Valid/ready stream bundle used between ring-buffer stages.
//            master drives valid/data and samples ready;
//            slave samples valid/data and drives ready.
// Revision : 1.0 - initial release
// ============================================================================
interface rb_if #(
    parameter int DW = 16
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface
`default_nettype wire

// File: rtl/ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : ring_buffer
// Purpose  : Small first-word-fall-through FIFO on rb_if streams.
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset (pointers only)
//   i_bus  : write side (slave)  - ready = not full
//   o_bus  : read side (master)  - valid = not empty, data shows head word
// DEPTH must be a power of two.
// Revision : 1.0 - initial release
// ============================================================================
module ring_buffer #(
    parameter int DW    = 16,
    parameter int DEPTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    rb_if.slave  i_bus,
    rb_if.master o_bus
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] r_mem [DEPTH];
    // One extra pointer bit distinguishes full from empty.
    logic [AW:0]   r_wr_ptr;
    logic [AW:0]   r_rd_ptr;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;

    assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_push  = i_bus.valid && !w_full;
    assign w_pop   = o_bus.ready && !w_empty;

    assign i_bus.ready = !w_full;
    assign o_bus.valid = !w_empty;
    assign o_bus.data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_bus.data;
    end

endmodule
`default_nettype wire

// File: rtl/rb_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module   : rb_pkt_reader
// Purpose  : Parses length-prefixed packets from an rb_if stream, strips the
//            header word and forwards the payload with a last marker.
//            Malformed headers (length 0 or > MAX_LEN) are flagged and the
//            packet is discarded.
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   i_bus    : inbound stream (slave), usually a ring_buffer output
//   o_bus    : outbound payload stream (master), zero-latency pass-through
//   o_last   : marks the final payload word of a packet
//   busy     : high while a packet body is in progress
//   err_len  : one-cycle pulse after an illegal header is accepted
//   pkt_cnt  : packets fully delivered (wrapping)
//   drop_cnt : packets dropped (wrapping)
// Revision : 1.0 - initial release
// ============================================================================
module rb_pkt_reader
    import rb_pkt_pkg::*;
#(
    parameter type data_t  = logic [15:0],
    parameter int  DW      = $bits(data_t),
    parameter int  MAX_LEN = 256,
    parameter int  LW      = $clog2(MAX_LEN) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    rb_if.slave              i_bus,
    rb_if.master             o_bus,
    output logic             o_last,
    output logic             busy,
    output logic             err_len,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic [CNT_W-1:0] drop_cnt
);
    localparam logic [LW-1:0]    c_max_len = LW'(MAX_LEN);
    localparam logic [LW-1:0]    c_rem_one = LW'(1);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);

    pkt_state_t       r_state;
    logic [LW-1:0]    r_rem;
    logic             r_err_len;
    logic [CNT_W-1:0] r_pkt_cnt;
    logic [CNT_W-1:0] r_drop_cnt;

    logic [DW-1:0]    w_data;
    logic [LW-1:0]    w_len;

    assign w_data = i_bus.data;
    assign w_len  = LW'(hdr_len(64'(w_data), LW));

    // Outside PAYLOAD the reader always accepts (header or discarded word)
    // and never presents output; inside PAYLOAD it is a wire-through.
    always_comb begin
        i_bus.ready = 1'b1;
        o_bus.valid = 1'b0;
        o_bus.data  = w_data;
        if (r_state == PAYLOAD) begin
            o_bus.valid = i_bus.valid;
            i_bus.ready = o_bus.ready;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= HDR;
            r_rem      <= '0;
            r_err_len  <= 1'b0;
            r_pkt_cnt  <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_err_len <= 1'b0;
            case (r_state)
                HDR: begin
                    if (i_bus.valid) begin
                        if (w_len == '0) begin
                            // Empty packet: nothing to skip, count it as dropped now.
                            r_err_len  <= 1'b1;
                            r_drop_cnt <= r_drop_cnt + c_cnt_one;
                        end else if (w_len > c_max_len) begin
                            r_rem     <= w_len;
                            r_err_len <= 1'b1;
                            r_state   <= DROP;
                        end else begin
                            r_rem   <= w_len;
                            r_state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (i_bus.valid && o_bus.ready) begin
                        r_rem <= r_rem - c_rem_one;
                        if (r_rem == c_rem_one) begin
                            r_state   <= HDR;
                            r_pkt_cnt <= r_pkt_cnt + c_cnt_one;
                        end
                    end
                end
                DROP: begin
                    if (i_bus.valid) begin
                        r_rem <= r_rem - c_rem_one;
                        if (r_rem == c_rem_one) begin
                            r_state    <= HDR;
                            r_drop_cnt <= r_drop_cnt + c_cnt_one;
                        end
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    assign o_last   = (r_state == PAYLOAD) && (r_rem == c_rem_one);
    assign busy     = (r_state != HDR);
    assign err_len  = r_err_len;
    assign pkt_cnt  = r_pkt_cnt;
    assign drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rb_pkt_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rb_pkt_reader
// Purpose  : Self-checking bench: ring_buffer -> rb_pkt_reader, payload
//            checked against a scoreboard queue, counters against a table.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rb_pkt_reader;
    import rb_pkt_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rb_if #(.DW(16)) src_if ();
    rb_if #(.DW(16)) mid_if ();
    rb_if #(.DW(16)) out_if ();

    logic        o_last, busy, err_len;
    logic [15:0] pkt_cnt, drop_cnt;

    ring_buffer #(.DW(16), .DEPTH(16)) u_rb (
        .clk(clk), .rst_n(rst_n), .i_bus(src_if), .o_bus(mid_if)
    );

    rb_pkt_reader #(.data_t(logic [15:0]), .MAX_LEN(256)) dut (
        .clk(clk), .rst_n(rst_n), .i_bus(mid_if), .o_bus(out_if),
        .o_last(o_last), .busy(busy), .err_len(err_len),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [15:0] hdr;
        int          nw;
        bit          deliver;
        int          d_pkt;
        int          d_drop;
        int          errs;
    } vec_t;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          seq = 0;
    int          err_seen = 0;
    bit          busy_chk = 1'b0;
    bit          bp_mode = 1'b0;
    logic [16:0] exp_q[$];
    int          xfer_cyc[$];
    int          exp_pkt = 0;
    int          exp_drop = 0;
    vec_t        tbl[11];

    always @(posedge clk) cyc <= cyc + 1;

    // Downstream ready: constant 1, or the pattern 1,0,0,1 repeating.
    initial begin
        int ph;
        ph = 0;
        out_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode) begin
                out_if.ready = (ph == 0 || ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_if.ready = 1'b1;
                ph = 0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        logic [16:0] e;
        if (busy_chk) begin
            busy_chk = 1'b0;
            chk("busy_after_last", int'(busy), 0);
        end
        if (err_len) err_seen++;
        if (rst_n && bp_mode && busy && mid_if.valid)
            chk("ready_mirror", int'(mid_if.ready), int'(out_if.ready));
        if (rst_n && out_if.valid && out_if.ready) begin
            xfer_cyc.push_back(cyc);
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_out: got data %h last %b, want no output",
                         out_if.data, o_last);
            end else begin
                e = exp_q.pop_front();
                if ({o_last, out_if.data} !== e) begin
                    fails++;
                    $display("FAIL payload: got last %b data %h, want last %b data %h",
                             o_last, out_if.data, e[16], e[15:0]);
                end
            end
            if (o_last) busy_chk = 1'b1;
        end
    end

    task automatic push_word(input logic [15:0] d);
        int guard;
        guard = 0;
        src_if.valid = 1'b1;
        src_if.data  = d;
        forever begin
            @(negedge clk);
            if (src_if.ready) begin
                @(posedge clk);
                #1;
                break;
            end
            guard++;
            if (guard > 500) begin
                chk("push_timeout", 1, 0);
                break;
            end
        end
        src_if.valid = 1'b0;
    endtask

    task automatic push_pkt(input logic [15:0] hdr, input int n, input bit deliver);
        logic [15:0] d;
        push_word(hdr);
        for (int i = 0; i < n; i++) begin
            d = 16'(seq * 7 + 3);
            seq++;
            if (deliver) exp_q.push_back({(i == n - 1), d});
            push_word(d);
        end
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        forever begin
            @(negedge clk);
            if (!mid_if.valid && !busy && exp_q.size() == 0) break;
            guard++;
            if (guard > 2000) begin
                chk("drain_timeout", 1, 0);
                break;
            end
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        int guard;
        src_if.valid = 1'b0;
        src_if.data  = '0;

        tbl[0]  = '{16'd3,     3,   1'b1, 1, 0, 0};
        tbl[1]  = '{16'd1,     1,   1'b1, 1, 0, 0};
        tbl[2]  = '{16'd0,     0,   1'b0, 0, 1, 1};
        tbl[3]  = '{16'd1,     1,   1'b1, 1, 0, 0};
        tbl[4]  = '{16'd258,   258, 1'b0, 0, 1, 1};
        tbl[5]  = '{16'd1,     1,   1'b1, 1, 0, 0};
        tbl[6]  = '{16'd256,   256, 1'b1, 1, 0, 0};
        tbl[7]  = '{16'd257,   257, 1'b0, 0, 1, 1};
        tbl[8]  = '{16'hFE05,  5,   1'b1, 1, 0, 0};
        tbl[9]  = '{16'h0200,  0,   1'b0, 0, 1, 1};
        tbl[10] = '{16'd2,     2,   1'b1, 1, 0, 0};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid",    int'(out_if.valid), 0);
        chk("rst_last",     int'(o_last), 0);
        chk("rst_busy",     int'(busy), 0);
        chk("rst_err",      int'(err_len), 0);
        chk("rst_pkt_cnt",  int'(pkt_cnt), 0);
        chk("rst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single packet: payload on consecutive cycles
        xfer_cyc.delete();
        push_pkt(16'd3, 3, 1'b1);
        drain();
        exp_pkt++;
        chk("single_n", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("single_gap0", xfer_cyc[1] - xfer_cyc[0], 1);
            chk("single_gap1", xfer_cyc[2] - xfer_cyc[1], 1);
        end
        chk("single_pkt_cnt", int'(pkt_cnt), exp_pkt);

        // Back-to-back: one header bubble between X and Y
        xfer_cyc.delete();
        push_pkt(16'd1, 1, 1'b1);
        push_pkt(16'd2, 2, 1'b1);
        drain();
        exp_pkt += 2;
        chk("b2b_n", xfer_cyc.size(), 3);
        if (xfer_cyc.size() == 3) begin
            chk("b2b_gap_hdr", xfer_cyc[1] - xfer_cyc[0], 2);
            chk("b2b_gap_pay", xfer_cyc[2] - xfer_cyc[1], 1);
        end
        chk("b2b_pkt_cnt", int'(pkt_cnt), exp_pkt);

        // Table of packet shapes and header boundaries
        for (int i = 0; i < 11; i++) begin
            e0 = err_seen;
            push_pkt(tbl[i].hdr, tbl[i].nw, tbl[i].deliver);
            drain();
            exp_pkt  += tbl[i].d_pkt;
            exp_drop += tbl[i].d_drop;
            chk($sformatf("tbl%0d_pkt_cnt", i),  int'(pkt_cnt),  exp_pkt);
            chk($sformatf("tbl%0d_drop_cnt", i), int'(drop_cnt), exp_drop);
            chk($sformatf("tbl%0d_err", i),      err_seen - e0,  tbl[i].errs);
        end

        // Backpressure
        bp_mode = 1'b1;
        push_pkt(16'd4, 4, 1'b1);
        drain();
        bp_mode = 1'b0;
        exp_pkt++;
        chk("bp_pkt_cnt", int'(pkt_cnt), exp_pkt);

        // Reset in the middle of a len=5 packet after two payload words
        push_word(16'd5);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({1'b0, 16'(16'hC000 + i)});
            push_word(16'(16'hC000 + i));
        end
        guard = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0 && !mid_if.valid) break;
            guard++;
            if (guard > 200) begin
                chk("midpkt_timeout", 1, 0);
                break;
            end
        end
        chk("midpkt_busy", int'(busy), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_busy",     int'(busy), 0);
        chk("mrst_valid",    int'(out_if.valid), 0);
        chk("mrst_last",     int'(o_last), 0);
        chk("mrst_pkt_cnt",  int'(pkt_cnt), 0);
        chk("mrst_drop_cnt", int'(drop_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        exp_pkt  = 0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        push_pkt(16'd2, 2, 1'b1);
        drain();
        chk("post_rst_pkt_cnt",  int'(pkt_cnt), 1);
        chk("post_rst_drop_cnt", int'(drop_cnt), 0);
        chk("sb_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
